// File: rtl/bsk_cmd_pkg.sv
// Shared types and sizing helpers for the command qualification stage.
package bsk_cmd_pkg;

  localparam int MAX_CH = 32;

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    CONFIRM  = 3'd2,
    ACTIVE   = 3'd3,
    RELEASE  = 3'd4
  } ch_state_e;

  // Counter width able to hold the larger of the two duration limits.
  function automatic int cnt_w(input int confirm_cycles, input int release_cycles);
    int m;
    m = (confirm_cycles > release_cycles) ? confirm_cycles : release_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cmd_confirm_if.sv
// Command/event bundle between the filter front end and the control logic.
interface cmd_confirm_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] cmd_in;
  logic            evt_clr;
  logic [N_CH-1:0] evt_clr_mask;
  logic [N_CH-1:0] cmd_out;
  logic [N_CH-1:0] evt;
  logic            irq;
  logic            err_multi;

  modport master (
    output cmd_in, evt_clr, evt_clr_mask,
    input  cmd_out, evt, irq, err_multi
  );

  modport slave (
    input  cmd_in, evt_clr, evt_clr_mask,
    output cmd_out, evt, irq, err_multi
  );
endinterface

// File: rtl/cmd_confirm_ch.sv
// One command channel: minimum-duration confirm on assert and release,
// with a WAIT_LOW state that ignores the input until its first low sample.
module cmd_confirm_ch
  import bsk_cmd_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic cmd,
  output logic active,
  output logic enter
);

  localparam int CNT_W = cnt_w(CONFIRM_CYCLES, RELEASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch forms.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOW: if (!cmd) state_d = IDLE;
      IDLE: begin
        if (cmd) begin
          if (CONFIRM_CYCLES == 1) begin
            state_d = ACTIVE;
          end else begin
            state_d = CONFIRM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CONFIRM: begin
        if (!cmd) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CONF_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (!cmd) begin
          if (RELEASE_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        if (cmd) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign active = (state_q == ACTIVE) || (state_q == RELEASE);
  // Only a fresh assertion counts; bridging a short low gap does not.
  assign enter  = ((state_q == IDLE) || (state_q == CONFIRM)) && (state_d == ACTIVE);

endmodule

// File: rtl/cmd_confirm.sv
// Command qualification top: N_CH confirm channels, sticky event flags, irq.
// Optional multi-command error flag enabled by CMD_CONFIRM_MULTI_ERR_EN.
module cmd_confirm
  import bsk_cmd_pkg::*;
#(
  parameter int N_CH           = 8,
  parameter int CONFIRM_CYCLES = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input logic          clk,
  input logic          aclr_n,
  cmd_confirm_if.slave bus
);

  logic [N_CH-1:0] active;
  logic [N_CH-1:0] enter;
  logic [N_CH-1:0] evt_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cmd_confirm_ch #(
      .CONFIRM_CYCLES(CONFIRM_CYCLES),
      .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .aclr_n(aclr_n),
      .cmd   (bus.cmd_in[i]),
      .active(active[i]),
      .enter (enter[i])
    );
  end

  // A set on the same edge as a masked clear wins.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~(bus.evt_clr_mask & {N_CH{bus.evt_clr}})) | enter;
    end
  end

  assign bus.cmd_out = active;
  assign bus.evt     = evt_q;
  assign bus.irq     = |evt_q;

`ifdef CMD_CONFIRM_MULTI_ERR_EN
  logic err_q;

  // x & (x-1) is nonzero exactly when two or more bits are set.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= |(active & (active - 1'b1));
    end
  end

  assign bus.err_multi = err_q;
`else
  assign bus.err_multi = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_confirm.sv
// Scoreboard bench for cmd_confirm: a run-length model predicts outputs per edge.
module tb_cmd_confirm;

  localparam int N = 8;
  localparam int C = 4;
  localparam int R = 4;

  typedef struct {
    logic [N-1:0] cmd_out;
    logic [N-1:0] evt;
    logic         irq;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic aclr_n = 1'b0;

  cmd_confirm_if #(.N_CH(N)) bus ();

  cmd_confirm #(
    .N_CH(N),
    .CONFIRM_CYCLES(C),
    .RELEASE_CYCLES(R)
  ) dut (
    .clk   (clk),
    .aclr_n(aclr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  // Reference model state
  bit           armed[N];
  int           hi[N];
  int           lo[N];
  logic [N-1:0] m_out;
  logic [N-1:0] m_evt;
  logic         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      armed[i] = 1'b0;
      hi[i] = 0;
      lo[i] = 0;
    end
    m_out = '0;
    m_evt = '0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] cin, input logic clr, input logic [N-1:0] mask);
    logic [N-1:0] prev_out;
    logic [N-1:0] rise;
    prev_out = m_out;
    rise = '0;
    for (int i = 0; i < N; i++) begin
      if (!armed[i]) begin
        if (!cin[i]) armed[i] = 1'b1;
      end else if (cin[i]) begin
        lo[i] = 0;
        if (!m_out[i]) begin
          hi[i]++;
          if (hi[i] >= C) begin
            m_out[i] = 1'b1;
            rise[i] = 1'b1;
            hi[i] = 0;
          end
        end
      end else begin
        hi[i] = 0;
        if (m_out[i]) begin
          lo[i]++;
          if (lo[i] >= R) begin
            m_out[i] = 1'b0;
            lo[i] = 0;
          end
        end
      end
    end
    m_evt = (m_evt & ~(clr ? mask : '0)) | rise;
`ifdef CMD_CONFIRM_MULTI_ERR_EN
    m_err = ($countones(prev_out) >= 2);
`else
    m_err = 1'b0;
`endif
  endtask

  task automatic step(input logic [N-1:0] cin, input logic clr = 1'b0, input logic [N-1:0] mask = '0);
    exp_t e;
    bus.cmd_in = cin;
    bus.evt_clr = clr;
    bus.evt_clr_mask = mask;
    model_step(cin, clr, mask);
    sb.push_back('{cmd_out: m_out, evt: m_evt, irq: |m_evt, err: m_err});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("cmd_out", bus.cmd_out, e.cmd_out);
      check("evt", bus.evt, e.evt);
      check("irq", bus.irq, e.irq);
      check("err_multi", bus.err_multi, e.err);
    end
    bus.evt_clr = 1'b0;
  endtask

  task automatic repeat_step(input logic [N-1:0] cin, input int n);
    for (int k = 0; k < n; k++) step(cin);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_out"}, bus.cmd_out, '0);
    check({tag, "_evt"}, bus.evt, '0);
    check({tag, "_irq"}, bus.irq, 1'b0);
    check({tag, "_err"}, bus.err_multi, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    aclr_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    aclr_n = 1'b1;
  endtask

  logic [N-1:0] cur;

  initial begin
    bus.cmd_in = '1;
    bus.evt_clr = 1'b0;
    bus.evt_clr_mask = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    aclr_n = 1'b1;

    // All inputs high out of reset: nothing may confirm
    repeat_step(8'hFF, 20);
    // ch0 drops once, then a full confirm run
    step(8'hFE);
    repeat_step(8'hFF, 4);
    check("ch0_assert", bus.cmd_out[0], 1'b1);

    // Arm everything and let ch0 release, then clear events
    repeat_step(8'h00, 6);
    step(8'h00, 1'b1, 8'hFF);

    // ch1: short pulses rejected, full pulse accepted then released
    repeat_step(8'h02, 3);
    repeat_step(8'h00, 2);
    repeat_step(8'h02, 3);
    repeat_step(8'h00, 2);
    repeat_step(8'h02, 4);
    repeat_step(8'h00, 6);

    // ch2: 3-cycle gap bridged, 4-cycle gap releases
    step(8'h00, 1'b1, 8'hFF);
    repeat_step(8'h04, 4);
    step(8'h00, 1'b1, 8'h04);
    repeat_step(8'h00, 2);
    repeat_step(8'h04, 2);
    repeat_step(8'h00, 6);

    // Build evt=05, then clear bit0 on the edge ch0 re-asserts
    step(8'h00, 1'b1, 8'hFF);
    repeat_step(8'h05, 4);
    check("evt_05", bus.evt, 8'h05);
    repeat_step(8'h04, 4);
    repeat_step(8'h05, 3);
    step(8'h05, 1'b1, 8'h01);
    check("set_wins", bus.evt[0], 1'b1);
    step(8'h05, 1'b1, 8'h04);
    check("clr_mask04", bus.evt, 8'h01);
    check("irq_held", bus.irq, 1'b1);

    // ch0 and ch3 together, then ch3 released
    repeat_step(8'h0D, 4);
    repeat_step(8'h05, 6);
    repeat_step(8'h00, 6);

    // Async reset with ch6 ACTIVE and ch5 in CONFIRM
    repeat_step(8'h40, 4);
    repeat_step(8'h60, 2);
    async_reset();
    repeat_step(8'h60, 6);
    step(8'h00);
    repeat_step(8'h60, 4);
    check("rearm_ch56", bus.cmd_out, 8'h60);
    repeat_step(8'h00, 6);

    // Randomised levels with occasional masked clears
    cur = '0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) cur[i] = ~cur[i];
      step(cur, ($urandom_range(3) == 0), N'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_confirm.md
# cmd_confirm

Command qualification stage fed directly by the per-line glitch/stretch filters. Takes N filtered command levels, confirms each with a minimum-duration check on assert and release, and presents clean command levels plus sticky rising-edge event flags with a mask-clear handshake to the control logic. Also suppresses the false command that the upstream filters present while leaving reset, since their outputs come out of reset high.

## Interface
- N_CH, 8, number of command channels (1..32)
- CONFIRM_CYCLES, 4, consecutive high samples required to assert a command (1..255)
- RELEASE_CYCLES, 4, consecutive low samples required to release a command (1..255)
- clk  input  1  system clock
- aclr_n  input  1  reset; one clock, reset asynchronous and active-low
- cmd_in  input  N_CH  filtered command levels, synchronous to clk
- evt_clr  input  1  one-cycle clear strobe
- evt_clr_mask  input  N_CH  event bits cleared when evt_clr=1
- cmd_out  output  N_CH  confirmed command levels
- evt  output  N_CH  sticky rising-edge flags of cmd_out
- irq  output  1  OR of evt
- err_multi  output  1  more than one command active (see Configuration)

## Operation
- Per-channel FSM, states: WAIT_LOW, IDLE, CONFIRM, ACTIVE, RELEASE. Per-channel counter width $clog2(max(CONFIRM_CYCLES,RELEASE_CYCLES)+1). The counter saturates and never wraps.
- WAIT_LOW: reset state. Input is ignored until the first low sample, then the FSM goes to IDLE. A channel held high from reset never asserts.
- IDLE, in=1:
  - CONFIRM_CYCLES=1: go to ACTIVE.
  - Otherwise: go to CONFIRM with cnt=1.
- CONFIRM:
  - in=0: go to IDLE and clear cnt.
  - in=1 and cnt+1=CONFIRM_CYCLES: go to ACTIVE.
  - Otherwise: cnt++.
- ACTIVE, in=0:
  - RELEASE_CYCLES=1: go to IDLE.
  - Otherwise: go to RELEASE with cnt=1.
- RELEASE:
  - in=1: go back to ACTIVE, clear cnt. The command stays asserted with no gap.
  - in=0 and cnt+1=RELEASE_CYCLES: go to IDLE.
  - Otherwise: cnt++.
- cmd_out[i]=1 exactly in ACTIVE and RELEASE. It is registered and decoded from the state register.
- evt[i] is set on the edge at which channel i enters ACTIVE from IDLE or CONFIRM. Re-entry from RELEASE does not set it.
- evt[i] clears on an edge with evt_clr=1 and evt_clr_mask[i]=1. If a set and a clear hit the same edge, set wins. Unmasked bits are unaffected.
- irq = |evt, combinational from the evt register.

## Timing
- Reset values: cmd_out=0, evt=0, irq=0, err_multi=0; all FSMs in WAIT_LOW with cnt=0.
- Assert latency: with cmd_in[i] sampled high at edges t0..t0+C-1 (C=CONFIRM_CYCLES), cmd_out[i] and evt[i] are high after edge t0+C-1.
- Release latency: with cmd_in[i] sampled low at edges t1..t1+R-1 (R=RELEASE_CYCLES), cmd_out[i] is low after edge t1+R-1.
- Pulse rejection: high pulses shorter than C samples produce no output. Low gaps shorter than R samples are bridged.
- evt_clr takes effect at the sampling edge; evt and irq drop after that edge.
- aclr_n asserted mid-operation forces reset values immediately, regardless of clk. After release, every channel requires a low sample before it can confirm again.
- Channels are fully independent. Simultaneous assertion on several channels sets all corresponding evt bits on the same edge.

## Configuration
- CMD_CONFIRM_MULTI_ERR_EN defined:
  - err_multi is registered and goes high one edge after cmd_out has two or more bits set.
  - It goes low one edge after the count drops to 0 or 1.
- CMD_CONFIRM_MULTI_ERR_EN undefined: err_multi is a constant 0, and no popcount logic is synthesized.

## Structure
- Package bsk_cmd_pkg holds:
  - the channel state enum (WAIT_LOW, IDLE, CONFIRM, ACTIVE, RELEASE);
  - the CNT_W function/localparam;
  - a max-channel constant of 32.
- Sub-module cmd_confirm_ch: one channel FSM plus counter, parameterized by CONFIRM_CYCLES/RELEASE_CYCLES. Its outputs are the active level and an enter-ACTIVE strobe.
- The top level holds:
  - the N_CH generate loop;
  - the evt register with clear logic;
  - irq;
  - the optional err_multi logic.

## Test plan
- Reset with cmd_in=all 1 held 20 cycles, C=4 -> cmd_out=0, evt=0 throughout. Drop ch0 for 1 cycle then raise for 4 -> cmd_out[0]=1, evt[0]=1 after 4th high edge.
- C=4: ch1 high pulses of 3 cycles, then a pulse of 4 cycles -> no output for the 3-cycle pulses; cmd_out[1] high for the 4-cycle pulse, deasserting after R=4 low samples.
- R=4, ch2 active, low gaps of 3 cycles then 4 cycles -> cmd_out[2] stays 1 across the 3-cycle gap with evt not re-set; it drops after the 4th low sample of the 4-cycle gap.
- evt=8'h05, pulse evt_clr with mask 8'h01 on the same edge ch0 re-asserts -> evt[0] stays 1 (set wins). Next clear with mask 8'h04 -> evt=8'h01; irq remains 1.
- Macro defined: ch0 and ch3 active together -> err_multi=1 one edge later; release ch3 -> err_multi=0 one edge after cmd_out[3] falls. Macro undefined: err_multi=0 always.
- aclr_n pulsed low while ch5 is in CONFIRM and ch6 is ACTIVE -> all outputs 0 immediately. Both channels need a low sample and a full C-sample high run afterwards.
